// File: rtl/nic8_pkg.sv
// Shared types and constants for the nic8 fetch stage.
// Holds the sequencer state encoding, IR field positions and reset PC.
package nic8_pkg;

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    EXEC      = 2'd1,
    STEP_WAIT = 2'd2,
    HALT      = 2'd3
  } state_t;

  localparam int IR_BIT7    = 7;
  localparam int IR_DEST_HI = 6;
  localparam int IR_DEST_LO = 4;
  localparam int IR_BIT3    = 3;
  localparam int IR_SRC_HI  = 2;
  localparam int IR_SRC_LO  = 0;

  localparam int RESET_PC = 0;

endpackage

// File: rtl/fetch_sequencer_pc_counter.sv
// Program counter register: load, increment or hold.
// Arithmetic wraps modulo 2^W; reset is synchronous.
module pc_counter
  import nic8_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);

  // Load has priority over increment; otherwise hold.
  always_ff @(posedge clk) begin
    if (reset)     q <= W'(RESET_PC);
    else if (load) q <= din;
    else if (inc)  q <= q + W'(1);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch stage: owns PC and IR, sequences FETCH/EXEC, halts on self-jump.
// Optional SINGLE_STEP_EN adds stepReq and a STEP_WAIT state after EXEC.
module fetch_sequencer
  import nic8_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int ICOUNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          romData,
  input  logic [7:0]          dbus,
  input  logic                assertRom,
  input  logic                doJumpBar,
  output logic [PC_W-1:0]     romAddr,
  output logic [7:0]          ir,
  output logic                execPhase,
  output logic                halted,
  output logic [ICOUNT_W-1:0] icount
`ifdef SINGLE_STEP_EN
  ,
  input  logic                stepReq
`endif
);

  state_t state, state_n;

  logic [PC_W-1:0] instr_addr;
  logic [PC_W-1:0] target;
  logic            pc_load;
  logic            pc_inc;
  logic            ir_load;
  logic            retire;
  logic            exec_n;
  logic            halt_n;
  logic            self_jump;

  assign target    = PC_W'(dbus);
  assign self_jump = !doJumpBar && (target == instr_addr);

  pc_counter #(.W(PC_W)) u_pc (
    .clk   (clk),
    .reset (reset),
    .load  (pc_load),
    .inc   (pc_inc),
    .din   (target),
    .q     (romAddr)
  );

  // State, IR, opcode address and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      ir         <= 8'h00;
      instr_addr <= PC_W'(RESET_PC);
      execPhase  <= 1'b0;
      halted     <= 1'b0;
      icount     <= '0;
    end else begin
      state     <= state_n;
      execPhase <= exec_n;
      halted    <= halt_n;
      if (ir_load) begin
        ir         <= romData;
        instr_addr <= romAddr;
      end
      if (retire) icount <= icount + ICOUNT_W'(1);
    end
  end

  // Next state and PC control; jump beats the immediate skip.
  always_comb begin
    state_n = state;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    ir_load = 1'b0;
    retire  = 1'b0;
    exec_n  = 1'b0;
    halt_n  = halted;
    unique case (state)
      FETCH: begin
        ir_load = 1'b1;
        pc_inc  = 1'b1;
        exec_n  = 1'b1;
        state_n = EXEC;
      end
      EXEC: begin
        retire = 1'b1;
        if (self_jump) begin
          halt_n  = 1'b1;
          state_n = HALT;
        end else begin
          if (!doJumpBar)    pc_load = 1'b1;
          else if (assertRom) pc_inc = 1'b1;
`ifdef SINGLE_STEP_EN
          state_n = STEP_WAIT;
`else
          state_n = FETCH;
`endif
        end
      end
      STEP_WAIT: begin
`ifdef SINGLE_STEP_EN
        if (stepReq) state_n = FETCH;
`else
        state_n = FETCH;
`endif
      end
      HALT: begin
        state_n = HALT;
      end
    endcase
  end

endmodule
